uart_tx_core: RTL and testbench

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_tx_core.sv | 133 +++++++++++++
 tb/tb_uart_tx_core.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// uart_tx_core
//   Serial transmitter for 8N1 framing, with an optional even-parity bit
//   inserted between D7 and the stop bit.
//   Frame layout: start(0), D0..D7 LSB first, [parity], stop(1). Each bit is
//   held for CLK_DIV clocks. After the stop bit, a one-cycle DONE state
//   drives the o_tx_done pulse.
//
// Parameters
//   CLK_DIV    clock cycles per bit (2..65535)
//   PARITY_EN  1 = insert an even-parity bit
//
// Ports
//   clk          system clock; all logic runs on the rising edge
//   rst_n        asynchronous, active-low reset
//   i_tx_start   send request; level-sampled, honoured only in IDLE
//   i_tx_data    byte to send; sampled on the acceptance edge only
//   o_tx_d       serial line (registered, idles high)
//   o_tx_busy    high while a frame is in flight (through DONE)
//   o_tx_done    one-cycle pulse once the stop bit has completed
module uart_tx_core #(
    parameter int unsigned CLK_DIV   = 434,
    parameter int unsigned PARITY_EN = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_d,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] bit_tmr;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          bit_end;
    logic          accept;

    assign bit_end = (bit_tmr == BIT_LAST);
    assign accept  = (state == IDLE) && i_tx_start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_tx_start) state_nxt = START;
            START:   if (bit_end)    state_nxt = DATA;
            DATA:    if (bit_end && bit_cnt == 3'd7)
                         state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_end)    state_nxt = STOP;
            STOP:    if (bit_end)    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit timer. Every state change except IDLE->START and DONE->IDLE falls
    // on a bit boundary, and the timer is already 0 in IDLE and DONE, so
    // clearing on bit_end also covers every state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bit_tmr <= '0;
        else if (state == IDLE || state == DONE || bit_end)
            bit_tmr <= '0;
        else
            bit_tmr <= bit_tmr + 1'b1;
    end

    // Data bit index; used only in DATA, and held at 0 elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bit_cnt <= '0;
        else if (state != DATA)
            bit_cnt <= '0;
        else if (bit_end)
            bit_cnt <= bit_cnt + 3'd1;
    end

    // Shift register. Parity is taken from the byte at acceptance, because
    // the register no longer holds the whole byte once it starts shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            par_bit <= 1'b0;
        end else if (accept) begin
            shreg   <= i_tx_data;
            par_bit <= ^i_tx_data;
        end else if (state == DATA && bit_end) begin
            shreg   <= {1'b0, shreg[7:1]};
        end
    end

    // Outputs are registered from the current state, so they trail the
    // state by one clock. The line is then driven only from a flop, and the
    // start bit begins on the edge after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_tx_d    <= 1'b1;
            o_tx_busy <= 1'b0;
            o_tx_done <= 1'b0;
        end else begin
            case (state)
                START:   o_tx_d <= 1'b0;
                DATA:    o_tx_d <= shreg[0];
                PARITY:  o_tx_d <= par_bit;
                default: o_tx_d <= 1'b1;
            endcase
            o_tx_busy <= (state != IDLE);
            o_tx_done <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start [3];
    logic [7:0] data  [3];
    logic       tx    [3];
    logic       busy  [3];
    logic       done  [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // u0: CLK_DIV=4, no parity; u1: CLK_DIV=4, parity; u2: CLK_DIV=2, no parity
    uart_tx_core #(.CLK_DIV(4), .PARITY_EN(0)) u0 (
        .clk(clk), .rst_n(rst_n), .i_tx_start(start[0]), .i_tx_data(data[0]),
        .o_tx_d(tx[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]));
    uart_tx_core #(.CLK_DIV(4), .PARITY_EN(1)) u1 (
        .clk(clk), .rst_n(rst_n), .i_tx_start(start[1]), .i_tx_data(data[1]),
        .o_tx_d(tx[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]));
    uart_tx_core #(.CLK_DIV(2), .PARITY_EN(0)) u2 (
        .clk(clk), .rst_n(rst_n), .i_tx_start(start[2]), .i_tx_data(data[2]),
        .o_tx_d(tx[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pos = clock edges since acceptance (-1 = idle). After edge p, the line
    // carries frame bit (p-1)/CD for p = 1..NB*CD, then DONE at NB*CD+1.
    function automatic int cd(input int i);
        return (i == 2) ? 2 : 4;
    endfunction

    function automatic int nbits(input int i);
        return (i == 1) ? 11 : 10;
    endfunction

    function automatic logic bitval(input int i, input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (i == 1 && k == 9) return ^b;
        return 1'b1;
    endfunction

    int         pos   [3];
    logic [7:0] fbyte [3];

    function automatic logic [2:0] expect_out(input int i);
        int p;
        p = pos[i];
        if (p <= 0) return 3'b100;
        if (p <= nbits(i) * cd(i)) return {bitval(i, fbyte[i], (p - 1) / cd(i)), 2'b10};
        return 3'b111;
    endfunction

    // Compare process: advance the model on each rising edge, check 1 time unit later.
    initial begin
        logic [2:0] e;
        for (int i = 0; i < 3; i++) pos[i] = -1;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    pos[i] = -1;
                end else begin
                    if (pos[i] >= 0) begin
                        pos[i]++;
                        if (pos[i] > nbits(i) * cd(i) + 1) pos[i] = -1;
                    end
                    if (pos[i] < 0 && start[i]) begin
                        pos[i]   = 0;
                        fbyte[i] = data[i];
                    end
                end
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                e = expect_out(i);
                chk($sformatf("u%0d.tx", i),   {31'd0, tx[i]},   {31'd0, e[2]});
                chk($sformatf("u%0d.busy", i), {31'd0, busy[i]}, {31'd0, e[1]});
                chk($sformatf("u%0d.done", i), {31'd0, done[i]}, {31'd0, e[0]});
            end
        end
    end

    // Send one byte on an idle instance and record the line for 63 cycles.
    // line[c] = o_tx_d after edge k+c (k = acceptance edge).
    task automatic measure(input int i, input logic [7:0] b, output int done_lat,
                           output int busy_cnt, output logic [63:0] line);
        @(negedge clk);
        start[i] = 1'b1;
        data[i]  = b;
        @(negedge clk);
        start[i] = 1'b0;
        data[i]  = ~b;
        done_lat = -1;
        busy_cnt = 0;
        line     = '0;
        for (int c = 1; c < 64; c++) begin
            @(posedge clk);
            #2;
            line[c] = tx[i];
            if (busy[i]) busy_cnt++;
            if (done[i] && done_lat < 0) done_lat = c;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          lat, bcnt, run;
        logic [63:0] line;
        int          a5  [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        int          b81 [10] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        int          b55 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            data[i]  = 8'h00;
        end
        #1 rst_n = 1'b0;

        // Reset state; a request held during reset must not start a frame early
        start[0] = 1'b1;
        data[0]  = 8'h12;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst.tx",   {31'd0, tx[i]},   32'd1);
            chk("rst.busy", {31'd0, busy[i]}, 32'd0);
            chk("rst.done", {31'd0, done[i]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (50) @(negedge clk);

        // 0xA5, no parity
        measure(0, 8'hA5, lat, bcnt, line);
        chk("a5.done_lat", lat, 41);
        chk("a5.busy_cnt", bcnt, 41);
        for (int k = 0; k < 10; k++) chk($sformatf("a5.bit%0d", k), {31'd0, line[2 + 4*k]}, a5[k]);

        // Parity instance: 0x07 -> parity 1, 0x03 -> parity 0
        measure(1, 8'h07, lat, bcnt, line);
        chk("p07.done_lat", lat, 45);
        chk("p07.busy_cnt", bcnt, 45);
        chk("p07.parity", {31'd0, line[2 + 4*9]}, 32'd1);
        chk("p07.stop",   {31'd0, line[2 + 4*10]}, 32'd1);
        measure(1, 8'h03, lat, bcnt, line);
        chk("p03.parity", {31'd0, line[2 + 4*9]}, 32'd0);

        // Minimum divider
        measure(2, 8'h81, lat, bcnt, line);
        chk("d2.done_lat", lat, 21);
        chk("d2.busy_cnt", bcnt, 21);
        for (int k = 0; k < 10; k++) chk($sformatf("d2.bit%0d", k), {31'd0, line[2 + 2*k]}, b81[k]);

        // Back-to-back with start held: 4 stop + DONE + 1 IDLE = 6 high cycles
        @(negedge clk);
        start[0] = 1'b1;
        data[0]  = 8'h00;
        @(negedge clk);
        data[0] = 8'hFF;
        repeat (36) @(negedge clk);
        chk("b2b.d7_low", {31'd0, tx[0]}, 32'd0);
        run = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx[0]) run++;
            else break;
        end
        chk("b2b.gap", run, 6);
        start[0] = 1'b0;
        repeat (60) @(negedge clk);

        // Request pulsed mid-frame is ignored
        @(negedge clk);
        start[1] = 1'b1;
        data[1]  = 8'h3C;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (12) @(negedge clk);
        start[1] = 1'b1;
        data[1]  = 8'hC3;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (60) @(negedge clk);

        // Reset during D3 of 0x96 (D3 = 0), then a clean 0x55 frame
        @(negedge clk);
        start[0] = 1'b1;
        data[0]  = 8'h96;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("rstmid.d3", {31'd0, tx[0]}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.tx",   {31'd0, tx[0]},   32'd1);
        chk("rstmid.busy", {31'd0, busy[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        measure(0, 8'h55, lat, bcnt, line);
        chk("p55.done_lat", lat, 41);
        for (int k = 0; k < 10; k++) chk($sformatf("p55.bit%0d", k), {31'd0, line[2 + 4*k]}, b55[k]);

        // Random traffic on all three instances with occasional resets
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                start[i] = ($urandom_range(0, 3) == 0);
                data[i]  = 8'($urandom);
            end
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        repeat (60) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
